// File: rtl/cache_axi_pkg.sv
// Shared encodings for the cache<->AXI bridge: transfer types, AXI burst constants, FSM states.
package cache_axi_pkg;

  typedef enum logic [2:0] {
    T_BYTE = 3'b000,
    T_HALF = 3'b001,
    T_WORD = 3'b010,
    T_LINE = 3'b100
  } xfer_type_e;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'd2;
  localparam logic [7:0] LEN_LINE   = 8'd3;
  localparam logic [7:0] LEN_SINGLE = 8'd0;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_RESP} wr_state_e;

  // A line is four word beats; everything else is one beat of its natural size.
  function automatic logic [7:0] burst_len(input logic [2:0] t);
    return (t == T_LINE) ? LEN_LINE : LEN_SINGLE;
  endfunction

  function automatic logic [2:0] burst_size(input logic [2:0] t);
    return (t == T_LINE) ? SIZE_WORD : {1'b0, t[1:0]};
  endfunction

endpackage

// File: rtl/cache_axi_bridge_if.sv
// Cache-side request/return signals and the AXI master channels of the bridge.
interface cache_axi_bridge_if;
  logic         rd_req, rd_rdy, ret_valid, ret_last;
  logic [2:0]   rd_type;
  logic [31:0]  rd_addr, ret_data;
  logic         wr_req, wr_rdy;
  logic [2:0]   wr_type;
  logic [31:0]  wr_addr;
  logic [3:0]   wr_wstrb;
  logic [127:0] wr_data;
  logic [3:0]   arid, awid, wid, rid, bid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rvalid, rready, rlast;
  logic         awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]   wstrb;

  modport master (
    input  rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    output rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input  rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wid, wdata, wstrb, wlast, wvalid, input wready,
    input  bid, bresp, bvalid, output bready
  );

  modport slave (
    output rd_req, rd_type, rd_addr, wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
    input  rd_rdy, ret_valid, ret_last, ret_data, wr_rdy,
    input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input  wid, wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready
  );
endinterface

// File: rtl/cache_axi_wr_engine.sv
// Write-back engine: buffers one dirty line (or single write) and drives AW/W/B for it.
module cache_axi_wr_engine
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_wr_req,
  input  logic [2:0]   i_wr_type,
  input  logic [31:0]  i_wr_addr,
  input  logic [3:0]   i_wr_wstrb,
  input  logic [127:0] i_wr_data,
  output logic         o_wr_rdy,
  output logic         o_busy,
  output logic [27:0]  o_line_tag,
  output logic [3:0]   o_awid,
  output logic [31:0]  o_awaddr,
  output logic [7:0]   o_awlen,
  output logic [2:0]   o_awsize,
  output logic [1:0]   o_awburst,
  output logic         o_awvalid,
  input  logic         i_awready,
  output logic [3:0]   o_wid,
  output logic [31:0]  o_wdata,
  output logic [3:0]   o_wstrb,
  output logic         o_wlast,
  output logic         o_wvalid,
  input  logic         i_wready,
  input  logic         i_bvalid,
  output logic         o_bready
);

  wr_state_e    r_state, w_state_nxt;
  logic [31:0]  r_addr;
  logic [2:0]   r_type;
  logic [3:0]   r_wstrb;
  logic [127:0] r_data;
  logic [1:0]   r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= W_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == W_AW && i_awready)
        r_cnt <= '0;
      else if (o_wvalid && i_wready)
        r_cnt <= r_cnt + 2'd1;
    end
  end

  // Payload registers only capture on acceptance, so they need no reset.
  always_ff @(posedge clk) begin
    if (i_wr_req && o_wr_rdy) begin
      r_addr  <= i_wr_addr;
      r_type  <= i_wr_type;
      r_wstrb <= i_wr_wstrb;
      r_data  <= i_wr_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_wr_rdy    = 1'b0;
    o_awvalid   = 1'b0;
    o_wvalid    = 1'b0;
    o_bready    = 1'b0;
    case (r_state)
      W_IDLE: begin
        o_wr_rdy = resetn;
        if (i_wr_req && resetn) w_state_nxt = W_AW;
      end
      W_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        o_wvalid = 1'b1;
        if (i_wready && o_wlast) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        o_bready = 1'b1;
        if (i_bvalid) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  assign o_busy     = (r_state != W_IDLE);
  assign o_line_tag = r_addr[31:4];
  assign o_awid     = WR_ID;
  assign o_awaddr   = r_addr;
  assign o_awlen    = burst_len(r_type);
  assign o_awsize   = burst_size(r_type);
  assign o_awburst  = BURST_INCR;
  assign o_wid      = WR_ID;
  assign o_wdata    = r_data[{r_cnt, 5'd0} +: 32];
  assign o_wstrb    = (r_type == T_LINE) ? 4'hF : r_wstrb;
  assign o_wlast    = (r_cnt == o_awlen[1:0]);

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache refill/write-back responder turning cache requests into AXI bursts; read FSM and RAW guard live here.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic clk,
  input  logic resetn,
  cache_axi_bridge_if.master bus
);

  rd_state_e   r_rd_state, w_rd_state_nxt;
  logic [31:0] r_rd_addr;
  logic [2:0]  r_rd_type;
  logic        w_rd_rdy, w_wr_rdy, w_wr_busy, w_hazard, w_unused;
  logic [27:0] w_wr_tag;

  cache_axi_wr_engine #(.WR_ID(WR_ID)) u_wr (
    .clk        (clk),
    .resetn     (resetn),
    .i_wr_req   (bus.wr_req),
    .i_wr_type  (bus.wr_type),
    .i_wr_addr  (bus.wr_addr),
    .i_wr_wstrb (bus.wr_wstrb),
    .i_wr_data  (bus.wr_data),
    .o_wr_rdy   (w_wr_rdy),
    .o_busy     (w_wr_busy),
    .o_line_tag (w_wr_tag),
    .o_awid     (bus.awid),
    .o_awaddr   (bus.awaddr),
    .o_awlen    (bus.awlen),
    .o_awsize   (bus.awsize),
    .o_awburst  (bus.awburst),
    .o_awvalid  (bus.awvalid),
    .i_awready  (bus.awready),
    .o_wid      (bus.wid),
    .o_wdata    (bus.wdata),
    .o_wstrb    (bus.wstrb),
    .o_wlast    (bus.wlast),
    .o_wvalid   (bus.wvalid),
    .i_wready   (bus.wready),
    .i_bvalid   (bus.bvalid),
    .o_bready   (bus.bready)
  );

  // A refill of a line that is being (or about to be) written back would return stale memory data.
  assign w_hazard = (w_wr_busy && bus.rd_addr[31:4] == w_wr_tag) ||
                    (bus.wr_req && w_wr_rdy && bus.wr_addr[31:4] == bus.rd_addr[31:4]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rd_state <= R_IDLE;
    else         r_rd_state <= w_rd_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (bus.rd_req && w_rd_rdy) begin
      r_rd_addr <= bus.rd_addr;
      r_rd_type <= bus.rd_type;
    end
  end

  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_rdy       = 1'b0;
    bus.arvalid    = 1'b0;
    bus.rready     = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        w_rd_rdy = resetn & ~w_hazard;
        if (bus.rd_req && w_rd_rdy) w_rd_state_nxt = R_AR;
      end
      R_AR: begin
        bus.arvalid = 1'b1;
        if (bus.arready) w_rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        bus.rready = 1'b1;
        if (bus.rvalid && bus.rlast) w_rd_state_nxt = R_IDLE;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  assign bus.rd_rdy    = w_rd_rdy;
  assign bus.wr_rdy    = w_wr_rdy;
  assign bus.arid      = RD_ID;
  assign bus.araddr    = r_rd_addr;
  assign bus.arlen     = burst_len(r_rd_type);
  assign bus.arsize    = burst_size(r_rd_type);
  assign bus.arburst   = BURST_INCR;
  assign bus.ret_valid = bus.rready & bus.rvalid;
  assign bus.ret_last  = bus.rready & bus.rvalid & bus.rlast;
  assign bus.ret_data  = bus.rdata;
  assign w_unused      = ^{bus.rid, bus.rresp, bus.bid, bus.bresp};

endmodule
